// File: rtl/result_writeback_pkg.sv
// result_writeback_pkg: channel encodings and interrupt vector layout shared by decode and writeback
package result_writeback_pkg;
  localparam logic [3:0] CH_NONE = 4'd0;
  localparam logic [3:0] CH_R1   = 4'd1;
  localparam logic [3:0] CH_R2   = 4'd2;
  localparam logic [3:0] CH_R3   = 4'd3;
  localparam logic [3:0] CH_R4   = 4'd4;
  localparam logic [3:0] CH_R5   = 4'd5;
  localparam logic [3:0] CH_R6   = 4'd6;
  localparam logic [3:0] CH_R7   = 4'd7;
  localparam logic [3:0] CH_R8   = 4'd8;
  localparam logic [3:0] CH_FLAG = 4'd9;
  localparam logic [3:0] CH_PC   = 4'd10;
  localparam logic [3:0] CH_TPC  = 4'd11;
  localparam logic [3:0] CH_IPC  = 4'd12;
  localparam logic [3:0] CH_SP   = 4'd13;
  localparam logic [3:0] CH_TLB  = 4'd14;
  localparam logic [3:0] CH_SYS  = 4'd15;
  localparam logic [1:0] Y2_NONE = 2'd0;
  localparam logic [1:0] Y2_FLAG = 2'd1;
  localparam logic [1:0] Y2_SP   = 2'd2;
  localparam int IVT_SLOT_LSB = 2;
  localparam int IVT_NUM_W    = 8;
  localparam int IVT_BASE_LSB = IVT_SLOT_LSB + IVT_NUM_W;
  // Vector table entry: table base from sys, vector number scaled to a 4-byte slot.
  function automatic logic [31:0] ivt_addr(input logic [31:0] base, input logic [IVT_NUM_W-1:0] num);
    return {base[31:IVT_BASE_LSB], num, {IVT_SLOT_LSB{1'b0}}};
  endfunction
endpackage

// File: rtl/result_writeback_if.sv
// result_writeback_if: execute-result bus into writeback and architectural register view out of it
interface result_writeback_if;
  logic        isStop;
  logic        this_isRunning;
  logic [31:0] thisOrderAddress;
  logic [31:0] y1;
  logic [3:0]  y1_channel_select;
  logic [31:0] y2;
  logic [1:0]  y2_channel_select;
  logic        interrupt;
  logic [7:0]  interrupt_num;
  logic [31:0] r1, r2, r3, r4, r5, r6, r7, r8;
  logic [31:0] flag, pc, tpc, ipc, sp, tlb, sys;
  logic        pc_redirect;
  logic [31:0] instret;
  modport master (
    output isStop, this_isRunning, thisOrderAddress, y1, y1_channel_select, y2, y2_channel_select,
           interrupt, interrupt_num,
    input  r1, r2, r3, r4, r5, r6, r7, r8, flag, pc, tpc, ipc, sp, tlb, sys, pc_redirect, instret
  );
  modport slave (
    input  isStop, this_isRunning, thisOrderAddress, y1, y1_channel_select, y2, y2_channel_select,
           interrupt, interrupt_num,
    output r1, r2, r3, r4, r5, r6, r7, r8, flag, pc, tpc, ipc, sp, tlb, sys, pc_redirect, instret
  );
endinterface

// File: rtl/result_writeback_arch_reg_file.sv
// arch_reg_file: 15 architectural registers, port A beats port B, interrupt entry beats both on pc/ipc
module arch_reg_file
  import result_writeback_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] SP_RESET = 32'h0000_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_a_i,
  input  logic [3:0]  sel_a_i,
  input  logic [31:0] data_a_i,
  input  logic        we_b_i,
  input  logic [3:0]  sel_b_i,
  input  logic [31:0] data_b_i,
  input  logic        irq_we_i,
  input  logic [31:0] irq_pc_i,
  input  logic [31:0] irq_ipc_i,
  output logic [31:0] regs_o [1:15]
);
  logic [31:0] regs_q [1:15];
  logic [31:0] regs_d [1:15];
  // Per-register next value with write-port priority: interrupt, then A, then B.
  always_comb begin
    for (int i = 1; i < 16; i++)
      regs_d[i] = (we_a_i && sel_a_i == 4'(i)) ? data_a_i :
                  (we_b_i && sel_b_i == 4'(i)) ? data_b_i : regs_q[i];
    if (irq_we_i) begin
      regs_d[CH_PC]  = irq_pc_i;
      regs_d[CH_IPC] = irq_ipc_i;
    end
  end
  // Register storage with pc/sp reset vectors.
  always_ff @(posedge clk) begin
    for (int i = 1; i < 16; i++)
      regs_q[i] <= rst ? ((4'(i) == CH_PC) ? PC_RESET : (4'(i) == CH_SP) ? SP_RESET : 32'h0) : regs_d[i];
  end
  assign regs_o = regs_q;
endmodule

// File: rtl/result_writeback.sv
// result_writeback: commits execute results and interrupt entry into the architectural registers
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter logic [31:0] SP_RESET    = 32'h0000_FFFC,
  parameter int          ORDER_BYTES = 4
) (
  input logic               clk,
  input logic               rst,
  result_writeback_if.slave wb
);
  logic        commit, a_we, b_we, irq_we, redirect_d, redirect_q;
  logic [3:0]  b_sel;
  logic [31:0] ipc_d, instret_d, instret_q;
  logic [31:0] regs [1:15];
  // Commit qualification and write-port steering; interrupt entry owns pc/ipc.
  always_comb begin
    commit     = wb.this_isRunning && !wb.isStop && !rst;
    b_sel      = (wb.y2_channel_select == Y2_FLAG) ? CH_FLAG : (wb.y2_channel_select == Y2_SP) ? CH_SP : CH_NONE;
    a_we       = commit && wb.y1_channel_select != CH_NONE &&
                 !(wb.interrupt && (wb.y1_channel_select == CH_PC || wb.y1_channel_select == CH_IPC));
    b_we       = commit && b_sel != CH_NONE;
    irq_we     = commit && wb.interrupt;
    ipc_d      = (wb.y1_channel_select == CH_PC) ? wb.y1 : wb.thisOrderAddress + 32'(ORDER_BYTES);
    redirect_d = commit && (wb.y1_channel_select == CH_PC || wb.interrupt);
    instret_d  = commit ? instret_q + 32'd1 : instret_q;
  end
  // Redirect pulse and retired-instruction counter.
  always_ff @(posedge clk) begin
    redirect_q <= rst ? 1'b0 : redirect_d;
    instret_q  <= rst ? 32'h0 : instret_d;
  end
  arch_reg_file #(.PC_RESET(PC_RESET), .SP_RESET(SP_RESET)) u_regs (
    .clk       (clk),
    .rst       (rst),
    .we_a_i    (a_we),
    .sel_a_i   (wb.y1_channel_select),
    .data_a_i  (wb.y1),
    .we_b_i    (b_we),
    .sel_b_i   (b_sel),
    .data_b_i  (wb.y2),
    .irq_we_i  (irq_we),
    .irq_pc_i  (ivt_addr(regs[CH_SYS], wb.interrupt_num)),
    .irq_ipc_i (ipc_d),
    .regs_o    (regs)
  );
  assign wb.r1          = regs[CH_R1];
  assign wb.r2          = regs[CH_R2];
  assign wb.r3          = regs[CH_R3];
  assign wb.r4          = regs[CH_R4];
  assign wb.r5          = regs[CH_R5];
  assign wb.r6          = regs[CH_R6];
  assign wb.r7          = regs[CH_R7];
  assign wb.r8          = regs[CH_R8];
  assign wb.flag        = regs[CH_FLAG];
  assign wb.pc          = regs[CH_PC];
  assign wb.tpc         = regs[CH_TPC];
  assign wb.ipc         = regs[CH_IPC];
  assign wb.sp          = regs[CH_SP];
  assign wb.tlb         = regs[CH_TLB];
  assign wb.sys         = regs[CH_SYS];
  assign wb.pc_redirect = redirect_q;
  assign wb.instret     = instret_q;
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: directed vectors against hand-computed register values
module tb_result_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  result_writeback_if wb_if ();
  result_writeback u_dut (.clk(clk), .rst(rst), .wb(wb_if));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input logic run, input logic stop, input logic [3:0] s1, input logic [31:0] d1,
                       input logic [1:0] s2, input logic [31:0] d2);
    wb_if.this_isRunning    = run;
    wb_if.isStop            = stop;
    wb_if.y1_channel_select = s1;
    wb_if.y1                = d1;
    wb_if.y2_channel_select = s2;
    wb_if.y2                = d2;
  endtask
  task automatic irq(input logic en, input logic [7:0] num, input logic [31:0] addr);
    wb_if.interrupt        = en;
    wb_if.interrupt_num    = num;
    wb_if.thisOrderAddress = addr;
  endtask
  initial begin
    drive(1'b0, 1'b0, 4'd0, 32'h0, 2'd0, 32'h0);
    irq(1'b0, 8'h0, 32'h0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_pc", wb_if.pc, 32'h0);
    check("rst_sp", wb_if.sp, 32'h0000_FFFC);
    check("rst_r1", wb_if.r1, 32'h0);
    check("rst_r8", wb_if.r8, 32'h0);
    check("rst_flag", wb_if.flag, 32'h0);
    check("rst_tpc", wb_if.tpc, 32'h0);
    check("rst_ipc", wb_if.ipc, 32'h0);
    check("rst_tlb", wb_if.tlb, 32'h0);
    check("rst_sys", wb_if.sys, 32'h0);
    check("rst_instret", wb_if.instret, 32'h0);
    check("rst_redirect", 32'(wb_if.pc_redirect), 32'h0);
    drive(1'b1, 1'b0, 4'd3, 32'h1234_5678, 2'd1, 32'h4);
    step();
    check("dual_r3", wb_if.r3, 32'h1234_5678);
    check("dual_flag", wb_if.flag, 32'h4);
    check("dual_instret", wb_if.instret, 32'd1);
    check("dual_redirect", 32'(wb_if.pc_redirect), 32'h0);
    drive(1'b1, 1'b0, 4'd13, 32'hA0, 2'd2, 32'hB0);
    step();
    check("coll_sp", wb_if.sp, 32'hA0);
    drive(1'b1, 1'b0, 4'd9, 32'h11, 2'd1, 32'h22);
    step();
    check("coll_flag", wb_if.flag, 32'h11);
    drive(1'b1, 1'b0, 4'd0, 32'h0, 2'd3, 32'h99);
    step();
    check("y2rsv_sp", wb_if.sp, 32'hA0);
    check("y2rsv_flag", wb_if.flag, 32'h11);
    check("y2rsv_instret", wb_if.instret, 32'd4);
    drive(1'b1, 1'b1, 4'd5, 32'h7, 2'd0, 32'h0);
    for (int i = 0; i < 3; i++) step();
    check("stall_r5", wb_if.r5, 32'h0);
    check("stall_instret", wb_if.instret, 32'd4);
    wb_if.isStop = 1'b0;
    step();
    check("unstall_r5", wb_if.r5, 32'h7);
    check("unstall_instret", wb_if.instret, 32'd5);
    drive(1'b0, 1'b0, 4'd5, 32'h9, 2'd2, 32'h33);
    step();
    step();
    check("idle_r5", wb_if.r5, 32'h7);
    check("idle_sp", wb_if.sp, 32'hA0);
    check("idle_instret", wb_if.instret, 32'd5);
    drive(1'b1, 1'b0, 4'd10, 32'h200, 2'd0, 32'h0);
    step();
    check("jmp_pc", wb_if.pc, 32'h200);
    check("jmp_redirect", 32'(wb_if.pc_redirect), 32'h1);
    wb_if.this_isRunning = 1'b0;
    step();
    check("jmp_redirect_end", 32'(wb_if.pc_redirect), 32'h0);
    drive(1'b1, 1'b0, 4'd10, 32'h400, 2'd0, 32'h0);
    step();
    check("b2b_redirect0", 32'(wb_if.pc_redirect), 32'h1);
    wb_if.y1 = 32'h404;
    step();
    check("b2b_redirect1", 32'(wb_if.pc_redirect), 32'h1);
    check("b2b_pc", wb_if.pc, 32'h404);
    drive(1'b1, 1'b0, 4'd15, 32'h0001_0000, 2'd0, 32'h0);
    step();
    check("sys_set", wb_if.sys, 32'h0001_0000);
    check("sys_redirect", 32'(wb_if.pc_redirect), 32'h0);
    check("sys_instret", wb_if.instret, 32'd9);
    drive(1'b1, 1'b0, 4'd2, 32'h9, 2'd0, 32'h0);
    irq(1'b1, 8'h05, 32'h100);
    step();
    check("irq_ipc", wb_if.ipc, 32'h104);
    check("irq_pc", wb_if.pc, 32'h0001_0014);
    check("irq_r2", wb_if.r2, 32'h9);
    check("irq_redirect", 32'(wb_if.pc_redirect), 32'h1);
    wb_if.this_isRunning = 1'b0;
    step();
    check("irq_redirect_end", 32'(wb_if.pc_redirect), 32'h0);
    drive(1'b1, 1'b0, 4'd10, 32'h300, 2'd0, 32'h0);
    step();
    check("irqj_ipc", wb_if.ipc, 32'h300);
    check("irqj_pc", wb_if.pc, 32'h0001_0014);
    drive(1'b1, 1'b0, 4'd12, 32'hDEAD, 2'd1, 32'h77);
    step();
    check("irqi_ipc", wb_if.ipc, 32'h104);
    check("irqi_flag", wb_if.flag, 32'h77);
    check("irqi_instret", wb_if.instret, 32'd12);
    drive(1'b1, 1'b1, 4'd0, 32'h0, 2'd0, 32'h0);
    irq(1'b1, 8'h07, 32'h200);
    step();
    step();
    check("irqs_pc", wb_if.pc, 32'h0001_0014);
    check("irqs_redirect", 32'(wb_if.pc_redirect), 32'h0);
    wb_if.isStop = 1'b0;
    step();
    check("irqs_pc_go", wb_if.pc, 32'h0001_001C);
    check("irqs_ipc_go", wb_if.ipc, 32'h204);
    check("irqs_instret", wb_if.instret, 32'd13);
    irq(1'b1, 8'h01, 32'hFFFF_FFFC);
    step();
    check("wrap_ipc", wb_if.ipc, 32'h0);
    check("wrap_pc", wb_if.pc, 32'h0001_0004);
    drive(1'b0, 1'b0, 4'd0, 32'h0, 2'd0, 32'h0);
    irq(1'b0, 8'h0, 32'h0);
    force u_dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.instret_q;
    wb_if.this_isRunning = 1'b1;
    step();
    check("instret_wrap", wb_if.instret, 32'h0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'd1, 32'h55, 2'd1, 32'h66);
    irq(1'b1, 8'h03, 32'h40);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'h0, 2'd0, 32'h0);
    irq(1'b0, 8'h0, 32'h0);
    check("mrst_r1", wb_if.r1, 32'h0);
    check("mrst_flag", wb_if.flag, 32'h0);
    check("mrst_pc", wb_if.pc, 32'h0);
    check("mrst_sp", wb_if.sp, 32'h0000_FFFC);
    check("mrst_instret", wb_if.instret, 32'h0);
    check("mrst_redirect", 32'(wb_if.pc_redirect), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
